lcd_power_sequencer: RTL and testbench

Controller for the LVDS LCD panel power-up/power-down sequence and backlight dimming. Drives panel VDD, gates the video stream (the timing generator's DataEnable/sync and the serializer reset release) and enables the backlight in the order and with the delays the panel datasheet requires. Aborts safely on pixel-clock MMCM lock loss. Sits beside the pixel-clock generator and LVDS serializer in the top level and runs on the 100 MHz buffered system clock.

---
 rtl/lcd_power_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_lcd_power_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_power_sequencer.sv
// lcd_power_sequencer
//
// Power-up and power-down sequencer for an LVDS LCD panel, plus backlight PWM.
// The panel supply, the video stream and the backlight are switched in datasheet
// order, with a programmable delay between each step. Loss of the pixel-clock
// MMCM lock while the panel is powered forces a full down sequence and sets a
// sticky fault flag.
//
// Build option: define LCD_BL_PWM_EN to build the brightness PWM. Without it,
// led_pwm simply follows led_en and brightness is ignored.
//
// Ports:
//   clk          100 MHz system clock
//   rst          synchronous active-high reset
//   enable_req   level request: panel on
//   mmcm_lckd    pixel-clock MMCM locked (synchronous to clk)
//   brightness   backlight duty, PWM_BITS wide
//   panel_vdd_en panel logic supply enable
//   video_en     video stream enable
//   led_en       backlight enable
//   led_pwm      backlight PWM
//   ready        panel fully on
//   lock_fault   sticky MMCM lock-loss flag
//   state        current sequencer state, for debug
module lcd_power_sequencer #(
    parameter int unsigned T_PWR_VID = 5_000_000,
    parameter int unsigned T_VID_BL  = 20_000_000,
    parameter int unsigned T_BL_VID  = 20_000_000,
    parameter int unsigned T_VID_PWR = 5_000_000,
    parameter int unsigned T_OFF_MIN = 50_000_000,
    parameter int unsigned PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_req,
    input  logic                mmcm_lckd,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                panel_vdd_en,
    output logic                video_en,
    output logic                led_en,
    output logic                led_pwm,
    output logic                ready,
    output logic                lock_fault,
    output logic [2:0]          state
);

    localparam int unsigned CntW = 26;

    // A timed state lasts T cycles: load T-1 on entry, leave when the counter hits 0.
    localparam logic [CntW-1:0] LdPwrVid = CntW'(T_PWR_VID - 1);
    localparam logic [CntW-1:0] LdVidBl  = CntW'(T_VID_BL - 1);
    localparam logic [CntW-1:0] LdBlVid  = CntW'(T_BL_VID - 1);
    localparam logic [CntW-1:0] LdVidPwr = CntW'(T_VID_PWR - 1);
    localparam logic [CntW-1:0] LdOffMin = CntW'(T_OFF_MIN - 1);

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StPwrUp   = 3'd1,
        StVidUp   = 3'd2,
        StOn      = 3'd3,
        StBlDown  = 3'd4,
        StVidDown = 3'd5,
        StCool    = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lock_fault_q, lock_fault_d;
    logic            vdd_q, vdd_d;
    logic            video_q, video_d;
    logic            led_q, led_d;
    logic            led_pwm_q, led_pwm_d;
    logic            drop_req;
    logic            cnt_zero;

    assign drop_req = ~enable_req | ~mmcm_lckd;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_zero ? '0 : cnt_q - CntW'(1);
        lock_fault_d = lock_fault_q;

        case (state_q)
            StOff: begin
                cnt_d = '0;
                if (!enable_req) begin
                    lock_fault_d = 1'b0;
                end
                if (enable_req && mmcm_lckd && !lock_fault_q) begin
                    state_d = StPwrUp;
                    cnt_d   = LdPwrVid;
                end
            end
            StPwrUp: begin
                // Video never started, so skip straight to the VDD-off delay.
                if (drop_req) begin
                    state_d = StVidDown;
                    cnt_d   = LdVidPwr;
                end else if (cnt_zero) begin
                    state_d = StVidUp;
                    cnt_d   = LdVidBl;
                end
            end
            StVidUp: begin
                if (drop_req) begin
                    state_d = StBlDown;
                    cnt_d   = LdBlVid;
                end else if (cnt_zero) begin
                    state_d = StOn;
                    cnt_d   = '0;
                end
            end
            StOn: begin
                if (drop_req) begin
                    state_d = StBlDown;
                    cnt_d   = LdBlVid;
                end
            end
            // Down states ignore requests and lock: the sequence always completes.
            StBlDown: begin
                if (cnt_zero) begin
                    state_d = StVidDown;
                    cnt_d   = LdVidPwr;
                end
            end
            StVidDown: begin
                if (cnt_zero) begin
                    state_d = StCool;
                    cnt_d   = LdOffMin;
                end
            end
            StCool: begin
                if (cnt_zero) begin
                    state_d = StOff;
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = '0;
            end
        endcase

        if (!mmcm_lckd && (state_q inside {StPwrUp, StVidUp, StOn})) begin
            lock_fault_d = 1'b1;
        end

        // Outputs are decoded from the next state so they flip on the same edge.
        vdd_d   = state_d inside {StPwrUp, StVidUp, StOn, StBlDown, StVidDown};
        video_d = state_d inside {StVidUp, StOn, StBlDown};
        led_d   = (state_d == StOn);
    end

`ifdef LCD_BL_PWM_EN
    localparam logic [PWM_BITS-1:0] PwmMax = '1;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        // New duty takes effect from the first cycle of the next period.
        duty_d    = (pwm_cnt_q == PwmMax) ? brightness : duty_q;
        led_pwm_d = led_d & ((duty_d == PwmMax) | (pwm_cnt_d < duty_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;

    always_comb begin
        led_pwm_d = led_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            lock_fault_q <= 1'b0;
            vdd_q        <= 1'b0;
            video_q      <= 1'b0;
            led_q        <= 1'b0;
            led_pwm_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lock_fault_q <= lock_fault_d;
            vdd_q        <= vdd_d;
            video_q      <= video_d;
            led_q        <= led_d;
            led_pwm_q    <= led_pwm_d;
        end
    end

    assign panel_vdd_en = vdd_q;
    assign video_en     = video_q;
    assign led_en       = led_q;
    assign ready        = led_q;
    assign led_pwm      = led_pwm_q;
    assign lock_fault   = lock_fault_q;
    assign state        = state_q;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Testbench for lcd_power_sequencer with short delays and a 4-bit PWM.
module tb_lcd_power_sequencer;

    localparam int unsigned TPV = 4;
    localparam int unsigned TVB = 6;
    localparam int unsigned TBV = 6;
    localparam int unsigned TVP = 4;
    localparam int unsigned TOM = 10;
    localparam int unsigned PB  = 4;
    localparam int PER = 1 << PB;
    localparam int MAXB = PER - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_req;
    logic          mmcm_lckd;
    logic [PB-1:0] brightness;
    logic          panel_vdd_en;
    logic          video_en;
    logic          led_en;
    logic          led_pwm;
    logic          ready;
    logic          lock_fault;
    logic [2:0]    state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rst_cyc  = 0;
    int hi       = 0;
    logic [PB-1:0] b_hist [4096];

    lcd_power_sequencer #(
        .T_PWR_VID (TPV),
        .T_VID_BL  (TVB),
        .T_BL_VID  (TBV),
        .T_VID_PWR (TVP),
        .T_OFF_MIN (TOM),
        .PWM_BITS  (PB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_req   (enable_req),
        .mmcm_lckd    (mmcm_lckd),
        .brightness   (brightness),
        .panel_vdd_en (panel_vdd_en),
        .video_en     (video_en),
        .led_en       (led_en),
        .led_pwm      (led_pwm),
        .ready        (ready),
        .lock_fault   (lock_fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Edge history: edge number, brightness seen at each edge, last reset edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        b_hist[(cyc + 1) % 4096] <= brightness;
        if (rst) rst_cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // PWM reference: period phase counted from the last reset edge; the duty of a
    // period is the brightness seen on the edge that started it (0 after reset).
    function automatic logic exp_pwm(input logic en);
`ifdef LCD_BL_PWM_EN
        int p = (cyc - rst_cyc) % PER;
        int s = cyc - p;
        int d = (s == rst_cyc) ? 0 : int'(b_hist[s % 4096]);
        return en && (d == MAXB || p < d);
`else
        return en;
`endif
    endfunction

    function automatic int exp_hi(input int b);
`ifdef LCD_BL_PWM_EN
        return (b == MAXB) ? PER : b;
`else
        return (b >= 0) ? PER : 0;
`endif
    endfunction

    // Expected state d cycles after leaving ON (or VID_UP) for the down path.
    function automatic int down_state(input int d);
        if (d <= int'(TBV)) return 4;
        if (d <= int'(TBV + TVP)) return 5;
        if (d <= int'(TBV + TVP + TOM)) return 6;
        return 0;
    endfunction

    // Expected state i cycles after enable_req was raised in OFF.
    function automatic int up_state(input int i);
        if (i <= int'(TPV)) return 1;
        if (i <= int'(TPV + TVB)) return 2;
        return 3;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input int st);
        logic vdd, vid, led;
        vdd = (st >= 1 && st <= 5);
        vid = (st >= 2 && st <= 4);
        led = (st == 3);
        chk({tag, ".state"}, 32'(state), st);
        chk({tag, ".vdd"}, 32'(panel_vdd_en), 32'(vdd));
        chk({tag, ".video"}, 32'(video_en), 32'(vid));
        chk({tag, ".led"}, 32'(led_en), 32'(led));
        chk({tag, ".ready"}, 32'(ready), 32'(led));
        chk({tag, ".pwm"}, 32'(led_pwm), 32'(exp_pwm(led)));
    endtask

    task automatic power_up(input string tag);
        enable_req = 1'b1;
        for (int i = 1; i <= int'(1 + TPV + TVB); i++) begin
            step();
            check_state(tag, up_state(i));
        end
    endtask

    task automatic power_down(input string tag, input bit pulse, input bit lf);
        for (int d = 1; d <= int'(TBV + TVP + TOM + 1); d++) begin
            step();
            check_state(tag, down_state(d));
            if (lf) chk({tag, ".lock_fault"}, 32'(lock_fault), 1);
            mmcm_lckd = 1'b1;
            if (pulse && d == int'(TBV + TVP + 2)) enable_req = 1'b1;
            if (pulse && d == int'(TBV + TVP + 3)) enable_req = 1'b0;
        end
    endtask

    task automatic run_on(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_state("on", 3);
            if (led_pwm === 1'b1) hi++;
        end
    endtask

    task automatic align_end();
        run_on(1);
        while ((cyc - rst_cyc) % PER != PER - 1) run_on(1);
    endtask

    task automatic count_period(input string tag, input int b);
        brightness = PB'(b);
        align_end();
        hi = 0;
        run_on(PER);
        chk(tag, hi, exp_hi(b));
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        enable_req = 1'b0;
        mmcm_lckd  = 1'b1;
        brightness = '0;
        step();
        step();
        check_state("reset", 0);
        chk("reset.lock_fault", 32'(lock_fault), 0);
        rst = 1'b0;
        step();
        check_state("idle", 0);

        power_up("pu");

        count_period("pwm5", 5);
        // Mid-period change to 12: rest of this period keeps duty 5.
        run_on(5);
        brightness = PB'(12);
        hi = 0;
        run_on(PER - 5);
`ifdef LCD_BL_PWM_EN
        chk("pwm_mid_old_duty", hi, 0);
`else
        chk("pwm_mid_old_duty", hi, PER - 5);
`endif
        hi = 0;
        run_on(PER);
        chk("pwm12", hi, exp_hi(12));
        count_period("pwm0", 0);
        count_period("pwm15", MAXB);
        for (int r = 0; r < 3; r++) count_period("pwm_rand", int'($urandom_range(0, MAXB)));

        run_on(int'($urandom_range(1, 20)));
        enable_req = 1'b0;
        power_down("pd", 1'b1, 1'b0);
        step();
        check_state("pd.stay_off", 0);

        // Lock loss in ON with request held high.
        brightness = PB'($urandom_range(1, MAXB));
        power_up("pu2");
        run_on(int'($urandom_range(1, 20)));
        mmcm_lckd = 1'b0;
        power_down("lock", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_state("lock.held_off", 0);
            chk("lock.sticky", 32'(lock_fault), 1);
        end
        enable_req = 1'b0;
        step();
        chk("lock.clear", 32'(lock_fault), 0);
        check_state("lock.cleared_off", 0);

        // Abort in PWR_UP: directed at cycle 2, then a random cycle.
        for (int r = 0; r < 2; r++) begin
            k = (r == 0) ? 2 : int'($urandom_range(1, TPV - 1));
            enable_req = 1'b1;
            for (int i = 1; i <= k; i++) begin
                step();
                check_state("abort_pu.up", up_state(i));
            end
            enable_req = 1'b0;
            for (int d = 1; d <= int'(TVP + TOM + 1); d++) begin
                step();
                check_state("abort_pu.down", down_state(d + int'(TBV)));
            end
        end

        // Abort in VID_UP at a random cycle.
        k = int'($urandom_range(TPV + 1, TPV + TVB - 1));
        enable_req = 1'b1;
        for (int i = 1; i <= k; i++) begin
            step();
            check_state("abort_vu.up", up_state(i));
        end
        enable_req = 1'b0;
        power_down("abort_vu.down", 1'b0, 1'b0);

        // Reset in the middle of VID_UP.
        enable_req = 1'b1;
        for (int i = 1; i <= int'(TPV + 3); i++) begin
            step();
            check_state("rst_mid.up", up_state(i));
        end
        rst = 1'b1;
        step();
        check_state("rst_mid", 0);
        chk("rst_mid.lock_fault", 32'(lock_fault), 0);
        rst = 1'b0;
        enable_req = 1'b0;
        step();
        check_state("rst_mid.after", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
